// File: rtl/stage4_ma_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage4_ma_if
//  Description : Memory bus between the MA pipeline stage and data memory.
//                master = MA stage (issues requests), slave = memory.
//  Signals     : mem_req   request, held until mem_ack
//                mem_we    1 = write, 0 = read
//                mem_addr  24-bit address
//                mem_wdata 24-bit store data
//                mem_ack   one-cycle completion pulse from memory
//                mem_rdata 24-bit read data, valid in the mem_ack cycle
//  Revision    : 1.0  initial release
// ============================================================================
interface stage4_ma_if;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_ack;
    logic [23:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/stage4_ma.sv
`default_nettype none
// ============================================================================
//  Module      : stage4_ma
//  Description : Memory-access pipeline stage. Loads/stores issue a request
//                on the memory bus and stall upstream until the memory acks;
//                everything else passes through to WB with 1-cycle latency.
//  Ports       : clk, rst (async, active-high)
//                enable_in + *_in        EX latch outputs
//                mem (stage4_ma_if)      memory bus, master side
//                stall_out               upstream must hold while 1
//                enable_out + *_out      one-cycle pulse of a completed op
//                fault_out               memory timeout indication
//  Config      : `define STAGE4MA_TIMEOUT_EN to abandon a request after 255
//                WAIT cycles without ack (fault_out pulses). Undefined: WAIT
//                lasts until ack and fault_out is tied to 0.
//  Opcodes     : instr[23:16]; R_LD=10 R_ST=11 I_LDi=20 I_STi=21 (hex)
//  Revision    : 1.0  initial release
// ============================================================================
module stage4_ma (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        enable_in,
    input  wire logic [23:0] pc_in,
    input  wire logic [23:0] instr_in,
    input  wire logic [23:0] result_in,
    input  wire logic [23:0] store_data_in,
    input  wire logic [3:0]  tgt_gp_in,
    input  wire logic [3:0]  tgt_sr_in,
    input  wire logic [3:0]  flags_in,
    input  wire logic        branch_taken_in,
    stage4_ma_if.master      mem,
    output logic             stall_out,
    output logic             enable_out,
    output logic [23:0]      pc_out,
    output logic [23:0]      instr_out,
    output logic [23:0]      result_out,
    output logic [3:0]       tgt_gp_out,
    output logic [3:0]       tgt_sr_out,
    output logic [3:0]       flags_out,
    output logic             branch_taken_out,
    output logic             fault_out
);

    localparam logic [7:0] OPC_R_LD  = 8'h10;
    localparam logic [7:0] OPC_R_ST  = 8'h11;
    localparam logic [7:0] OPC_I_LDI = 8'h20;
    localparam logic [7:0] OPC_I_STI = 8'h21;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        enable_q, enable_d;
    logic [23:0] pc_q, pc_d;
    logic [23:0] instr_q, instr_d;
    logic [23:0] result_q, result_d;
    logic [3:0]  tgt_gp_q, tgt_gp_d;
    logic [3:0]  tgt_sr_q, tgt_sr_d;
    logic [3:0]  flags_q, flags_d;
    logic        branch_q, branch_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] wdata_q, wdata_d;

    logic [7:0]  w_opc;
    logic        w_is_ld;
    logic        w_is_st;

    assign w_opc   = instr_in[23:16];
    assign w_is_ld = (w_opc == OPC_R_LD) || (w_opc == OPC_I_LDI);
    assign w_is_st = (w_opc == OPC_R_ST) || (w_opc == OPC_I_STI);

`ifdef STAGE4MA_TIMEOUT_EN
    // Value of the wait counter during the 255th WAIT cycle.
    localparam logic [7:0] C_TIMEOUT_LAST = 8'd254;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
`endif

    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        pc_d     = pc_q;
        instr_d  = instr_q;
        result_d = result_q;
        tgt_gp_d = tgt_gp_q;
        tgt_sr_d = tgt_sr_q;
        flags_d  = flags_q;
        branch_d = branch_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef STAGE4MA_TIMEOUT_EN
        cnt_d    = cnt_q;
        fault_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    // Output latches take the instruction at accept; for a
                    // memory op only result_out is revisited at completion.
                    pc_d     = pc_in;
                    instr_d  = instr_in;
                    result_d = result_in;
                    tgt_gp_d = tgt_gp_in;
                    tgt_sr_d = tgt_sr_in;
                    flags_d  = flags_in;
                    branch_d = branch_taken_in;
                    if (w_is_ld || w_is_st) begin
                        state_d = ST_WAIT;
                        req_d   = 1'b1;
                        we_d    = w_is_st;
                        addr_d  = result_in;
                        wdata_d = w_is_st ? store_data_in : 24'd0;
`ifdef STAGE4MA_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        enable_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    enable_d = 1'b1;
                    // A store reports its address, already held in result_q.
                    if (!we_q) begin
                        result_d = mem.mem_rdata;
                    end
                end
`ifdef STAGE4MA_TIMEOUT_EN
                else if (cnt_q == C_TIMEOUT_LAST) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    enable_d = 1'b1;
                    result_d = 24'd0;
                    fault_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            pc_q     <= 24'd0;
            instr_q  <= 24'd0;
            result_q <= 24'd0;
            tgt_gp_q <= 4'd0;
            tgt_sr_q <= 4'd0;
            flags_q  <= 4'd0;
            branch_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 24'd0;
            wdata_q  <= 24'd0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            tgt_gp_q <= tgt_gp_d;
            tgt_sr_q <= tgt_sr_d;
            flags_q  <= flags_d;
            branch_q <= branch_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef STAGE4MA_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
    assign fault_out = fault_q;
`else
    assign fault_out = 1'b0;
`endif

    assign stall_out        = (state_q == ST_WAIT);
    assign enable_out       = enable_q;
    assign pc_out           = pc_q;
    assign instr_out        = instr_q;
    assign result_out       = result_q;
    assign tgt_gp_out       = tgt_gp_q;
    assign tgt_sr_out       = tgt_sr_q;
    assign flags_out        = flags_q;
    assign branch_taken_out = branch_q;
    assign mem.mem_req      = req_q;
    assign mem.mem_we       = we_q;
    assign mem.mem_addr     = addr_q;
    assign mem.mem_wdata    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_stage4_ma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage4_ma
//  Description : Self-checking bench for stage4_ma. Stimulus pushes the
//                expected WB record into a queue; a monitor pops and compares
//                on every enable_out pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stage4_ma;

    localparam logic [7:0] OPC_R_ADD = 8'h01;
    localparam logic [7:0] OPC_R_LD  = 8'h10;
    localparam logic [7:0] OPC_R_ST  = 8'h11;
    localparam logic [7:0] OPC_I_LDI = 8'h20;
    localparam logic [7:0] OPC_I_STI = 8'h21;
    localparam logic [7:0] OPC_S_HLT = 8'hFF;

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] result;
        logic [3:0]  tgt_gp;
        logic [3:0]  tgt_sr;
        logic [3:0]  flags;
        logic        branch;
        logic        fault;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        enable_in = 1'b0;
    logic [23:0] pc_in = '0, instr_in = '0, result_in = '0, store_data_in = '0;
    logic [3:0]  tgt_gp_in = '0, tgt_sr_in = '0, flags_in = '0;
    logic        branch_taken_in = 1'b0;
    logic        stall_out, enable_out, branch_taken_out, fault_out;
    logic [23:0] pc_out, instr_out, result_out;
    logic [3:0]  tgt_gp_out, tgt_sr_out, flags_out;

    stage4_ma_if mif ();

    stage4_ma dut (
        .clk              (clk),
        .rst              (rst),
        .enable_in        (enable_in),
        .pc_in            (pc_in),
        .instr_in         (instr_in),
        .result_in        (result_in),
        .store_data_in    (store_data_in),
        .tgt_gp_in        (tgt_gp_in),
        .tgt_sr_in        (tgt_sr_in),
        .flags_in         (flags_in),
        .branch_taken_in  (branch_taken_in),
        .mem              (mif.master),
        .stall_out        (stall_out),
        .enable_out       (enable_out),
        .pc_out           (pc_out),
        .instr_out        (instr_out),
        .result_out       (result_out),
        .tgt_gp_out       (tgt_gp_out),
        .tgt_sr_out       (tgt_sr_out),
        .flags_out        (flags_out),
        .branch_taken_out (branch_taken_out),
        .fault_out        (fault_out)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    wb_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every enable_out pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && enable_out) begin
            if (sb.size() == 0) begin
                check("unexpected_enable_out", 1, 0);
            end else begin
                wb_t e;
                wb_t a;
                e = sb.pop_front();
                a = '{pc_out, instr_out, result_out, tgt_gp_out, tgt_sr_out,
                      flags_out, branch_taken_out, fault_out};
                check("wb_record", a, e);
            end
        end
    end

    task automatic drive(input logic [7:0] opc, input logic [23:0] pc, input logic [23:0] res,
                         input logic [23:0] sd, input logic [3:0] tg, input logic [3:0] ts,
                         input logic [3:0] fl, input logic br);
        enable_in       = 1'b1;
        pc_in           = pc;
        instr_in        = {opc, 16'h0001};
        result_in       = res;
        store_data_in   = sd;
        tgt_gp_in       = tg;
        tgt_sr_in       = ts;
        flags_in        = fl;
        branch_taken_in = br;
    endtask

    task automatic do_pass(input logic [7:0] opc, input logic [23:0] pc, input logic [23:0] res,
                           input logic [3:0] fl, input logic br);
        sb.push_back('{pc, {opc, 16'h0001}, res, 4'h1, 4'h2, fl, br, 1'b0});
        drive(opc, pc, res, 24'h777777, 4'h1, 4'h2, fl, br);
        @(posedge clk); #1;
        enable_in = 1'b0;
        check("pt_mem_req", mif.mem_req, 0);
        check("pt_stall", stall_out, 0);
    endtask

    // Memory op; ack is raised in the n-th request cycle (n >= 1).
    task automatic do_mem(input logic [7:0] opc, input logic [23:0] pc, input logic [23:0] addr,
                          input logic [23:0] sd, input logic [3:0] fl, input logic br,
                          input int n, input logic [23:0] rdata, input bit intrude);
        logic st;
        st = (opc == OPC_R_ST) || (opc == OPC_I_STI);
        sb.push_back('{pc, {opc, 16'h0001}, st ? addr : rdata, 4'h3, 4'h4, fl, br, 1'b0});
        drive(opc, pc, addr, sd, 4'h3, 4'h4, fl, br);
        @(posedge clk); #1;
        enable_in = 1'b0;
        for (int i = 1; i <= n; i++) begin
            check("mem_req", mif.mem_req, 1);
            check("mem_we", mif.mem_we, st);
            check("mem_addr", mif.mem_addr, addr);
            check("mem_wdata", mif.mem_wdata, st ? sd : 24'd0);
            check("stall", stall_out, 1);
            if (intrude && i == 1)
                drive(OPC_R_ADD, 24'hBADBAD, 24'h999999, 24'h0, 4'hF, 4'hF, 4'hF, 1'b1);
            if (i == n) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdata;
            end
            @(posedge clk); #1;
            enable_in     = 1'b0;
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 24'h0;
        end
        check("done_mem_req", mif.mem_req, 0);
        check("done_stall", stall_out, 0);
    endtask

    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mif.mem_req, 0);
        check("rst_stall", stall_out, 0);
        check("rst_enable", enable_out, 0);
        check("rst_fault", fault_out, 0);
        check("rst_result", result_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: pass-through ADD
        do_pass(OPC_R_ADD, 24'h000100, 24'h000123, 4'h5, 1'b0);
        // Scenario 2: load, ack in third request cycle
        do_mem(OPC_R_LD, 24'h000104, 24'h000040, 24'h0, 4'h6, 1'b1, 3, 24'hABCDEF, 1'b0);
        // Scenario 3: store, ack in first request cycle (back-to-back accept)
        do_mem(OPC_I_STI, 24'h000108, 24'h000010, 24'h00005A, 4'h7, 1'b0, 1, 24'h123456, 1'b0);
        // Immediate load right after completion, intruding enable during WAIT
        do_mem(OPC_I_LDI, 24'h00010C, 24'h000200, 24'h0, 4'h8, 1'b0, 3, 24'h00BEEF, 1'b1);
        // Stray ack while IDLE must not produce anything
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 24'h555555;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        check("stray_ack_req", mif.mem_req, 0);
        check("stray_ack_stall", stall_out, 0);
        do_mem(OPC_R_ST, 24'h000110, 24'hFFFFFF, 24'hA5A5A5, 4'h9, 1'b1, 2, 24'h0, 1'b0);
        do_pass(OPC_S_HLT, 24'h000114, 24'h00C0DE, 4'hA, 1'b1);

        // Scenario 5: reset in WAIT, ack after release is ignored
        drive(OPC_R_LD, 24'h000118, 24'h000300, 24'h0, 4'h1, 4'h1, 4'h1, 1'b1);
        @(posedge clk); #1;
        enable_in = 1'b0;
        check("s5_wait_stall", stall_out, 1);
        rst = 1'b1;
        #1;
        check("s5_rst_req", mif.mem_req, 0);
        check("s5_rst_stall", stall_out, 0);
        check("s5_rst_pc", pc_out, 0);
        check("s5_rst_addr", mif.mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 24'h777777;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        check("s5_after_req", mif.mem_req, 0);
        check("s5_after_enable", enable_out, 0);
        check("s5_after_result", result_out, 0);

`ifdef STAGE4MA_TIMEOUT_EN
        // Scenario 6: load never acked -> 255 request cycles, then fault
        begin
            int cyc;
            cyc = 0;
            sb.push_back('{24'h00011C, {OPC_R_LD, 16'h0001}, 24'h0, 4'h3, 4'h4, 4'hC, 1'b0, 1'b1});
            drive(OPC_R_LD, 24'h00011C, 24'h000400, 24'h0, 4'h3, 4'h4, 4'hC, 1'b0);
            @(posedge clk); #1;
            enable_in = 1'b0;
            while (mif.mem_req && cyc < 400) begin
                cyc++;
                @(posedge clk); #1;
            end
            check("s6_req_cycles", cyc, 255);
            check("s6_fault", fault_out, 1);
            check("s6_result", result_out, 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage4_ma.md
STAGE4_MA -- requirements
Module: stage4ma

Interface
REQ-001 clk  input  1  pipeline clock, all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 enable_in  input  1  EX stage holds a valid instruction.
REQ-004 pc_in, instr_in, result_in, store_data_in  input  24 each  EX latch outputs; result_in is the memory address for LD/ST.
REQ-005 tgt_gp_in, tgt_sr_in, flags_in  input  4 each  EX latch outputs.
REQ-006 branch_taken_in  input  1  EX branch-taken flag.
REQ-007 mem_req  output  1  memory request, registered.
REQ-008 mem_we  output  1  1=write, 0=read; valid while mem_req=1.
REQ-009 mem_addr, mem_wdata  output  24 each  address and store data; valid while mem_req=1.
REQ-010 mem_ack  input  1  one-cycle completion pulse from memory.
REQ-011 mem_rdata  input  24  read data; valid in the mem_ack cycle.
REQ-012 stall_out  output  1  upstream holds its inputs and must not advance.
REQ-013 enable_out  output  1  one-cycle pulse: outputs carry a completed instruction for WB.
REQ-014 pc_out, instr_out, result_out  output  24 each  latched to WB.
REQ-015 tgt_gp_out, tgt_sr_out, flags_out  output  4 each; branch_taken_out  output  1; fault_out  output  1 (Configuration).

Function
REQ-016 Opcode is instr_in[23:16]; OPC_R_LD and OPC_I_LDi are loads; OPC_R_ST and OPC_I_STi are stores; everything else is pass-through.
REQ-017 FSM states IDLE and WAIT; reset state IDLE.
REQ-018 Accept happens when state=IDLE and enable_in=1; all *_in fields are captured at accept.
REQ-019 Pass-through: at the edge after accept, all outputs take the captured values and enable_out=1 for exactly one cycle; state stays IDLE. Latency is 1.
REQ-020 Load/store accept: go to WAIT; from the next cycle mem_req=1, mem_addr=result_in, mem_we=1 for a store and 0 for a load, mem_wdata=store_data_in for a store and 0 for a load.
REQ-021 In WAIT: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
REQ-022 At the edge where mem_ack=1 in WAIT: mem_req goes to 0, state goes to IDLE, and enable_out=1 for one cycle.
REQ-023 On that completion, result_out=mem_rdata for a load; for a store, result_out=the address.
REQ-024 Minimum load/store latency is 2 cycles (accept, then ack in the first req cycle).
REQ-025 stall_out=1 whenever state=WAIT; otherwise 0.
REQ-026 enable_in while in WAIT is ignored; nothing is captured.
REQ-027 mem_ack while in IDLE is ignored.
REQ-028 A new accept is allowed in the IDLE cycle directly after completion (back-to-back operation).
REQ-029 An instruction with opcode OPC_S_HLT passes through normally.
REQ-030 flags_out and branch_taken_out always equal the captured inputs; the memory data never alters them.

Reset
REQ-031 rst forces state=IDLE.
REQ-032 rst forces all outputs to 0, including mem_req, stall_out, enable_out and fault_out.
REQ-033 rst during WAIT abandons the transaction; an ack arriving after rst is released is ignored per REQ-027.

Configuration
REQ-034 Macro STAGE4MA_TIMEOUT_EN controls the timeout feature.
REQ-035 With the macro defined:
- an 8-bit counter clears at accept and increments each WAIT cycle without mem_ack;
- when the counter reaches 255 without an ack, at that edge mem_req goes to 0, state goes to IDLE, enable_out=1, result_out=0 and fault_out=1, each for one cycle.
REQ-036 With the macro undefined: there is no counter, WAIT lasts indefinitely, and fault_out is tied to 0.

Verification
REQ-037 Scenario 1: OPC_R_ADD with result_in=24'h000123 accepted at cycle 0 -> cycle 1 has enable_out=1, result_out=24'h000123, mem_req=0.
REQ-038 Scenario 2: OPC_R_LD with result_in=24'h000040, ack at cycle 3, mem_rdata=24'hABCDEF -> cycles 1-3 have mem_req=1, mem_we=0, mem_addr=24'h000040, stall_out=1; cycle 4 has enable_out=1, result_out=24'hABCDEF.
REQ-039 Scenario 3: OPC_I_STi with result_in=24'h000010, store_data_in=24'h00005A, ack in the first req cycle -> mem_we=1, mem_wdata=24'h00005A; completion 2 cycles after accept; result_out=24'h000010.
REQ-040 Scenario 4: enable_in=1 with a different instruction during WAIT, plus a stray mem_ack while IDLE -> neither is captured; the output sequence is unchanged.
REQ-041 Scenario 5: rst asserted in WAIT, then ack one cycle after release -> all outputs 0 and no enable_out pulse.
REQ-042 Scenario 6 (STAGE4MA_TIMEOUT_EN): load with no ack -> mem_req drops after 255 WAIT cycles, fault_out=1 and result_out=0 for one cycle.
